// File: rtl/car_motion_controller.sv
// car_motion_controller: Moore FSM that moves an elevator car between three
// floors (0..2). It drives the motor and door, tracks the current floor and
// pulses floor_reached for one cycle whenever a floor is serviced.
//
// Optional build macro: DOOR_REOPEN_EN
//   defined   -> obstruction reopens a closing door and holds an open door
//   undefined -> obstruction is ignored; the door close always completes
module car_motion_controller #(
  parameter int TRAVEL_CYCLES     = 8,
  parameter int DOOR_OPEN_CYCLES  = 6,
  parameter int DOOR_CLOSE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] floor_requests,
  input  logic [1:0] target_floor,
  input  logic       door_hold,
  input  logic       obstruction,
  output logic [1:0] current_floor,
  output logic       floor_reached,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int MAX_DOOR   = (DOOR_OPEN_CYCLES > DOOR_CLOSE_CYCLES) ?
                              DOOR_OPEN_CYCLES : DOOR_CLOSE_CYCLES;
  localparam int MAX_CYCLES = (TRAVEL_CYCLES > MAX_DOOR) ? TRAVEL_CYCLES : MAX_DOOR;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LAST   = TW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [TW-1:0] CLOSE_LAST  = TW'(DOOR_CLOSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOVE_UP    = 3'd1,
    MOVE_DOWN  = 3'd2,
    ARRIVE     = 3'd3,
    DOOR_OPEN  = 3'd4,
    DOOR_CLOSE = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [1:0]    floor_next;
  logic [TW-1:0] travel_cnt, travel_next;
  logic [TW-1:0] door_cnt, door_next;
  logic          hold_door;

  // Request bit for a given floor; floor 3 does not exist and never requests.
  function automatic logic req_at(input logic [2:0] reqs, input logic [1:0] f);
    case (f)
      2'd0:    req_at = reqs[0];
      2'd1:    req_at = reqs[1];
      2'd2:    req_at = reqs[2];
      default: req_at = 1'b0;
    endcase
  endfunction

`ifdef DOOR_REOPEN_EN
  assign hold_door = door_hold | obstruction;
`else
  assign hold_door = door_hold;
`endif

  // State, floor and timer registers; everything returns to IDLE at floor 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values computed by the combinational block.
    if (rst) begin
      state         <= IDLE;
      current_floor <= 2'd0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
    end else begin
      state         <= state_next;
      current_floor <= floor_next;
      travel_cnt    <= travel_next;
      door_cnt      <= door_next;
    end
  end

  // Next-state, floor and timer logic; timers stay 0 unless their state persists.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next  = state;
    floor_next  = current_floor;
    travel_next = '0;
    door_next   = '0;

    unique case (state)
      IDLE: begin
        if (req_at(floor_requests, current_floor)) begin
          state_next = ARRIVE;
        end else if (target_floor == 2'd3 || floor_requests == 3'b000) begin
          state_next = IDLE;
        end else if (target_floor > current_floor) begin
          state_next = MOVE_UP;
        end else if (target_floor < current_floor) begin
          state_next = MOVE_DOWN;
        end
      end

      MOVE_UP: begin
        if (current_floor >= 2'd2) begin
          // Top floor: moving up is illegal, re-evaluate without moving.
          state_next = IDLE;
        end else if (travel_cnt == TRAVEL_LAST) begin
          floor_next = current_floor + 2'd1;
          if (floor_next == target_floor || req_at(floor_requests, floor_next))
            state_next = ARRIVE;
          else if (target_floor != 2'd3 && target_floor > floor_next)
            state_next = MOVE_UP;
          else
            state_next = IDLE;
        end else begin
          travel_next = travel_cnt + 1'b1;
        end
      end

      MOVE_DOWN: begin
        if (current_floor == 2'd0) begin
          // Bottom floor: moving down is illegal, re-evaluate without moving.
          state_next = IDLE;
        end else if (travel_cnt == TRAVEL_LAST) begin
          floor_next = current_floor - 2'd1;
          if (floor_next == target_floor || req_at(floor_requests, floor_next))
            state_next = ARRIVE;
          else if (target_floor < floor_next)
            state_next = MOVE_DOWN;
          else
            state_next = IDLE;
        end else begin
          travel_next = travel_cnt + 1'b1;
        end
      end

      ARRIVE: begin
        state_next = DOOR_OPEN;
      end

      DOOR_OPEN: begin
        if (hold_door) begin
          door_next = '0;
        end else if (door_cnt == OPEN_LAST) begin
          state_next = DOOR_CLOSE;
        end else begin
          door_next = door_cnt + 1'b1;
        end
      end

      DOOR_CLOSE: begin
`ifdef DOOR_REOPEN_EN
        if (obstruction) begin
          state_next = DOOR_OPEN;
        end else
`endif
        if (door_cnt == CLOSE_LAST) begin
          state_next = IDLE;
        end else begin
          door_next = door_cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded purely from the state register.
  always_comb begin
    motor_up      = (state == MOVE_UP);
    motor_down    = (state == MOVE_DOWN);
    door_open     = (state == DOOR_OPEN);
    floor_reached = (state == ARRIVE);
    busy          = (state != IDLE);
    state_dbg     = state;
  end

endmodule

// File: tb/tb_car_motion_controller.sv
// Directed testbench for car_motion_controller with TRAVEL_CYCLES=4,
// DOOR_OPEN_CYCLES=3, DOOR_CLOSE_CYCLES=2. The bench plays the request
// handler: it clears a serviced request bit right after the floor_reached pulse.
module tb_car_motion_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] floor_requests;
  logic [1:0] target_floor;
  logic       door_hold;
  logic       obstruction;
  logic [1:0] current_floor;
  logic       floor_reached;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  car_motion_controller #(
    .TRAVEL_CYCLES    (4),
    .DOOR_OPEN_CYCLES (3),
    .DOOR_CLOSE_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .floor_requests(floor_requests),
    .target_floor  (target_floor),
    .door_hold     (door_hold),
    .obstruction   (obstruction),
    .current_floor (current_floor),
    .floor_reached (floor_reached),
    .motor_up      (motor_up),
    .motor_down    (motor_down),
    .door_open     (door_open),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Checks state, floor and the full output set against hand-derived values.
  task automatic expect_all(input string tag, input logic [2:0] st, input logic [1:0] fl);
    check({tag, ".state"}, {5'd0, state_dbg}, {5'd0, st});
    check({tag, ".floor"}, {6'd0, current_floor}, {6'd0, fl});
    check({tag, ".outs"},
          {3'd0, motor_up, motor_down, door_open, floor_reached, busy},
          {3'd0, st == 3'd1, st == 3'd2, st == 3'd4, st == 3'd3, st != 3'd0});
  endtask

  initial begin
    rst            = 1'b1;
    floor_requests = 3'b100;
    target_floor   = 2'd2;
    door_hold      = 1'b0;
    obstruction    = 1'b0;

    // 1. Reset state, then travel 0 -> 2 and a full door cycle.
    #12;
    expect_all("reset", 3'd0, 2'd0);
    rst = 1'b0;
    step(1); expect_all("s1_up_start", 3'd1, 2'd0);
    step(3); expect_all("s1_up_mid", 3'd1, 2'd0);
    step(1); expect_all("s1_floor1", 3'd1, 2'd1);
    step(4); expect_all("s1_arrive", 3'd3, 2'd2);
    floor_requests = 3'b000;
    step(1); expect_all("s1_open0", 3'd4, 2'd2);
    step(2); expect_all("s1_open2", 3'd4, 2'd2);
    step(1); expect_all("s1_close0", 3'd5, 2'd2);
    step(1); expect_all("s1_close1", 3'd5, 2'd2);
    step(1); expect_all("s1_idle", 3'd0, 2'd2);

    // 2. Down from 2 with an intermediate stop at floor 1.
    floor_requests = 3'b011;
    target_floor   = 2'd0;
    step(1); expect_all("s2_down_start", 3'd2, 2'd2);
    step(4); expect_all("s2_stop1", 3'd3, 2'd1);
    floor_requests = 3'b001;
    step(1); expect_all("s2_open", 3'd4, 2'd1);
    step(3); expect_all("s2_close", 3'd5, 2'd1);
    step(2); expect_all("s2_idle1", 3'd0, 2'd1);
    step(1); expect_all("s2_down_again", 3'd2, 2'd1);
    step(4); expect_all("s2_arrive0", 3'd3, 2'd0);
    floor_requests = 3'b000;
    step(1); step(3); step(2);
    expect_all("s2_idle0", 3'd0, 2'd0);

    // 3. Request at the current floor services with no motion.
    floor_requests = 3'b001;
    step(1); expect_all("s3_arrive", 3'd3, 2'd0);
    floor_requests = 3'b000;
    step(1); expect_all("s3_open0", 3'd4, 2'd0);
    step(2); expect_all("s3_open2", 3'd4, 2'd0);
    step(1); expect_all("s3_close", 3'd5, 2'd0);
    step(2); expect_all("s3_idle", 3'd0, 2'd0);

    // 4. door_hold for 5 cycles keeps the door open, then 3 more open cycles.
    floor_requests = 3'b001;
    step(1); expect_all("s4_arrive", 3'd3, 2'd0);
    floor_requests = 3'b000;
    step(2); expect_all("s4_open1", 3'd4, 2'd0);
    door_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1); expect_all("s4_held", 3'd4, 2'd0);
    end
    door_hold = 1'b0;
    step(2); expect_all("s4_after_hold", 3'd4, 2'd0);
    step(1); expect_all("s4_close", 3'd5, 2'd0);
    step(2); expect_all("s4_idle", 3'd0, 2'd0);

    // 5. Asynchronous reset mid-travel, then invalid target stays IDLE.
    floor_requests = 3'b010;
    target_floor   = 2'd1;
    step(1); expect_all("s5_up", 3'd1, 2'd0);
    step(2);
    #2 rst = 1'b1;
    #1 expect_all("s5_async_rst", 3'd0, 2'd0);
    step(1);
    rst          = 1'b0;
    target_floor = 2'd3;
    step(3); expect_all("s5_target3_idle", 3'd0, 2'd0);

    // 6. Obstruction during the first close cycle.
    target_floor   = 2'd0;
    floor_requests = 3'b001;
    step(1); expect_all("s6_arrive", 3'd3, 2'd0);
    floor_requests = 3'b000;
    step(1); step(3); expect_all("s6_close0", 3'd5, 2'd0);
    obstruction = 1'b1;
    step(1);
    obstruction = 1'b0;
`ifdef DOOR_REOPEN_EN
    expect_all("s6_reopen", 3'd4, 2'd0);
    step(2); expect_all("s6_reopen2", 3'd4, 2'd0);
    step(1); expect_all("s6_close_again", 3'd5, 2'd0);
    step(2); expect_all("s6_idle", 3'd0, 2'd0);
`else
    expect_all("s6_close1", 3'd5, 2'd0);
    step(1); expect_all("s6_idle", 3'd0, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/car_motion_controller.md
Name: car_motion_controller

Overview:
- Sequences the elevator car for a 3-floor system (floors 0..2).
- Consumes the pending request vector and chosen target floor from the request handler.
- Drives the motor direction and door, tracks the current floor, and returns a one-cycle floor_reached pulse so the request handler can clear the serviced request.
- Single Moore FSM with travel and door timers.

Parameters:
TRAVEL_CYCLES, 8, clock cycles to move one floor (>=1)
DOOR_OPEN_CYCLES, 6, cycles door stays open (>=1)
DOOR_CLOSE_CYCLES, 2, cycles spent closing before car may move (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
floor_requests  input  3  pending request per floor, from request handler
target_floor  input  2  selected destination; value 3 is invalid
door_hold  input  1  door-open button; restarts open timer
obstruction  input  1  door sensor; used only when DOOR_REOPEN_EN is defined
current_floor  output  2  registered car position
floor_reached  output  1  one-cycle pulse on arrival/service at current_floor
motor_up  output  1  car moving up
motor_down  output  1  car moving down
door_open  output  1  door commanded open
busy  output  1  high in any state other than IDLE
state_dbg  output  3  encoded FSM state: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, ARRIVE=3, DOOR_OPEN=4, DOOR_CLOSE=5

Behaviour:
- Reset (asynchronous, any state, mid-travel included): state IDLE, current_floor=0, both timers=0, all outputs 0.
- Outputs are decoded from the state register (Moore).
  - motor_up=1 only in MOVE_UP; motor_down=1 only in MOVE_DOWN.
  - door_open=1 only in DOOR_OPEN; floor_reached=1 only in ARRIVE.
  - Motor and door are never active together; motor_up and motor_down are never both 1.
- IDLE, evaluated each cycle in this priority order:
  - floor_requests[current_floor]=1 -> ARRIVE.
  - target_floor=3 or floor_requests=0 -> stay IDLE.
  - target_floor>current_floor -> MOVE_UP.
  - target_floor<current_floor -> MOVE_DOWN.
  - Otherwise stay IDLE.
- MOVE_UP/MOVE_DOWN:
  - Travel timer counts 0..TRAVEL_CYCLES-1.
  - On the terminal count: current_floor += / -= 1 and the timer clears. Then, using the new floor:
    - floor == target_floor or floor_requests[new floor]=1 -> ARRIVE.
    - Else if target is still in the same direction -> continue in the same state.
    - Else -> IDLE, which re-evaluates.
  - Entering MOVE_UP at floor 2 or MOVE_DOWN at floor 0 is illegal: the FSM goes to IDLE next cycle without changing the floor. current_floor never wraps.
  - Changes to target_floor mid-segment take effect only at the next floor boundary.
- ARRIVE: exactly one cycle; floor_reached=1 -> DOOR_OPEN.
- DOOR_OPEN:
  - Door timer counts 0..DOOR_OPEN_CYCLES-1, then -> DOOR_CLOSE.
  - door_hold=1 holds the timer at 0, so the door stays open while held.
  - Requests arriving for the current floor do not re-pulse floor_reached.
- DOOR_CLOSE: timer counts 0..DOOR_CLOSE_CYCLES-1, then -> IDLE. door_open=0 throughout.
- Request-clear latency: the request handler clears its bit one cycle after the pulse. The stale bit is gone before IDLE is re-entered, so no duplicate service occurs.
- Timer width: $clog2(max parameter)+1 bits. Each timer clears on every state entry.

Optional Feature:
DOOR_REOPEN_EN
- Defined: obstruction=1 during DOOR_CLOSE -> DOOR_OPEN next cycle, door timer cleared, no floor_reached pulse. obstruction=1 during DOOR_OPEN behaves like door_hold.
- Undefined: the obstruction input is ignored; DOOR_CLOSE always completes.

Test Plan:
All scenarios use TRAVEL_CYCLES=4, DOOR_OPEN_CYCLES=3, DOOR_CLOSE_CYCLES=2.
1. Reset release, floor_requests=100, target=2 -> motor_up from next cycle; current_floor=1 after 4 cycles, =2 after 8; floor_reached 1 cycle; door_open 3 cycles; 2 close cycles; IDLE; busy low.
2. At floor 2, requests=011, target=0; floor 1 request present -> car stops at floor 1 (floor_reached, door cycle), then continues down to 0 after the handler clears bit 1.
3. IDLE at floor 0, floor_requests=001 -> ARRIVE next cycle with no motor activity; door_open 3 cycles.
4. door_hold asserted for 5 cycles mid DOOR_OPEN -> door_open stays 1 for hold duration plus 3 cycles; no second floor_reached.
5. rst asserted mid MOVE_UP between floors 0 and 1 -> immediately current_floor=0, motor_up=0, state_dbg=0; target=3 with requests nonzero -> stays IDLE.
6. DOOR_REOPEN_EN defined: obstruction pulse in DOOR_CLOSE cycle 1 -> door_open=1 next cycle for 3 cycles. Undefined: same stimulus -> IDLE after 2 close cycles.
